// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// seg7_pkg : shared 7-segment types, blank pattern and hex decode  | rev 1.0
// ============================================================================
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic seg7_t hex_to_seg(input logic [3:0] v);
    seg7_t r;
    case (v)
      4'h0:    r = 7'b1000000;
      4'h1:    r = 7'b1111001;
      4'h2:    r = 7'b0100100;
      4'h3:    r = 7'b0110000;
      4'h4:    r = 7'b0011001;
      4'h5:    r = 7'b0010010;
      4'h6:    r = 7'b0000010;
      4'h7:    r = 7'b1111000;
      4'h8:    r = 7'b0000000;
      4'h9:    r = 7'b0010000;
      4'hA:    r = 7'b0001000;
      4'hB:    r = 7'b0000011;
      4'hC:    r = 7'b1000110;
      4'hD:    r = 7'b0100001;
      4'hE:    r = 7'b0000110;
      default: r = 7'b0001110;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
// ============================================================================
// seg7_scan_timer : slot/digit counters, frame strobe, guard flag, blink phase | rev 1.0
// ============================================================================
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 256,
  localparam int K_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic [K_W-1:0] k,
  output logic           frame_end,
  output logic           guard,
  output logic           blink_phase
);

  localparam int S_W = $clog2(REFRESH_DIV);
  localparam int B_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [S_W-1:0] s;
  logic [B_W-1:0] frame_cnt;
  logic           slot_end;

  assign slot_end  = (s == S_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (k == K_W'(NUM_DIGITS - 1));
  assign guard     = (s < S_W'(BLANK_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s           <= '0;
      k           <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (slot_end) begin
        s <= '0;
        k <= (k == K_W'(NUM_DIGITS - 1)) ? '0 : k + 1'b1;
      end else begin
        s <= s + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == B_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_display.sv
`default_nettype none
// ============================================================================
// seg7_scan_display : multiplexed active-low 7-seg driver with shadow load | rev 1.0
// ============================================================================
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 4,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   en_i,
  input  logic [NUM_DIGITS-1:0]   blink_i,
  input  logic                    lzb_i,
  input  logic                    load_i,
  output seg7_t                   seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_o,
  output logic                    load_pending_o
);

  localparam int K_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [K_W-1:0]          k;
  logic                    frame_end;
  logic                    guard;
  logic                    blink_phase;

  logic [4*NUM_DIGITS-1:0] sh_digits;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_en;
  logic [NUM_DIGITS-1:0]   sh_blink;
  logic                    sh_lzb;
  logic                    pending;

  logic [3:0]              cur_val;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_blink;
  logic                    cur_upper_zero;
  logic                    zero_acc;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic                    hard_dark;
  logic                    lzb_dark;
  seg7_t                   seg_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   an_nx;

  seg7_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .k           (k),
    .frame_end   (frame_end),
    .guard       (guard),
    .blink_phase (blink_phase)
  );

  // Shadows only move at the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_en     <= '0;
      sh_blink  <= '0;
      sh_lzb    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      if (frame_end && (pending || load_i)) begin
        sh_digits <= digits_i;
        sh_dp     <= dp_i;
        sh_en     <= en_i;
        sh_blink  <= blink_i;
        sh_lzb    <= lzb_i;
      end
      if (frame_end)
        pending <= 1'b0;
      else if (load_i)
        pending <= 1'b1;
    end
  end

  // Scan from the top digit down so zero_acc means "this digit and all above are 0".
  always_comb begin
    cur_val        = '0;
    cur_dp         = 1'b0;
    cur_en         = 1'b0;
    cur_blink      = 1'b0;
    cur_upper_zero = 1'b0;
    an_sel         = '1;
    zero_acc       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_acc = zero_acc & (sh_digits[4*i +: 4] == 4'h0);
      if (k == K_W'(i)) begin
        cur_val        = sh_digits[4*i +: 4];
        cur_dp         = sh_dp[i];
        cur_en         = sh_en[i];
        cur_blink      = sh_blink[i];
        cur_upper_zero = zero_acc && (i != 0);
        an_sel[i]      = 1'b0;
      end
    end
  end

  assign hard_dark = !cur_en || (cur_blink && blink_phase);
  assign lzb_dark  = sh_lzb && cur_upper_zero;

  always_comb begin
    seg_nx = SEG_BLANK;
    dp_nx  = 1'b1;
    an_nx  = '1;
    if (!guard && !hard_dark) begin
      dp_nx = ~cur_dp;
      if (!lzb_dark) begin
        seg_nx = hex_to_seg(cur_val);
        an_nx  = an_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      an      <= '1;
      frame_o <= 1'b0;
    end else begin
      seg     <= seg_nx;
      dp      <= dp_nx;
      an      <= an_nx;
      frame_o <= frame_end;
    end
  end

  assign load_pending_o = pending;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_display.sv
`default_nettype none
// ============================================================================
// tb_seg7_scan_display : directed table-driven bench, 4 digits x 8-cycle slots | rev 1.0
// ============================================================================
module tb_seg7_scan_display;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int BF = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [15:0]  digits_i = '0;
  logic [3:0]   dp_i = '0;
  logic [3:0]   en_i = '0;
  logic [3:0]   blink_i = '0;
  logic         lzb_i = 1'b0;
  logic         load_i = 1'b0;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic         frame_o;
  logic         load_pending_o;
  logic [13:0]  obs;

  int n_checks = 0;
  int n_fail   = 0;

  // One record: inputs to load plus the per-digit appearance expected afterwards.
  typedef struct packed {
    logic [15:0]     digits;
    logic [3:0]      dpi;
    logic [3:0]      en;
    logic [3:0]      blink;
    logic            lzb;
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs [7];
  vec_t dark_v, blink_on_v, blink_off_v;

  seg7_scan_display #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .digits_i       (digits_i),
    .dp_i           (dp_i),
    .en_i           (en_i),
    .blink_i        (blink_i),
    .lzb_i          (lzb_i),
    .load_i         (load_i),
    .seg            (seg),
    .dp             (dp),
    .an             (an),
    .frame_o        (frame_o),
    .load_pending_o (load_pending_o)
  );

  always #5 clk = ~clk;

  assign obs = {an, seg, dp, frame_o, load_pending_o};

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {an,seg,dp,frame,pend}=%h required %h", name, act, exp);
    end
  endtask

  // Expected pins c cycles after a frame_o cycle (c=0 shows slot 0, s=0).
  function automatic logic [13:0] exp_at(input vec_t v, input int c);
    int   kk;
    int   j;
    logic fb;
    kk = c / RD;
    j  = c % RD;
    fb = (c == N*RD - 1);
    if (j < BC)
      return {4'hF, 7'h7F, 1'b1, fb, 1'b0};
    if (v.lit[kk])
      return {~(4'b0001 << kk), v.seg[kk], v.dpo[kk], fb, 1'b0};
    return {4'hF, 7'h7F, v.dpo[kk], fb, 1'b0};
  endfunction

  task automatic check_frame(input vec_t v, input string name);
    for (int c = 0; c < N*RD; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d", name, c), obs, exp_at(v, c));
    end
  endtask

  task automatic wait_frame(input string name);
    int t;
    t = 0;
    while (frame_o !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, " frame_o arrival"}, {13'd0, frame_o}, 14'd1);
  endtask

  task automatic set_inputs(input vec_t v);
    digits_i = v.digits;
    dp_i     = v.dpi;
    en_i     = v.en;
    blink_i  = v.blink;
    lzb_i    = v.lzb;
  endtask

  task automatic apply(input vec_t v);
    set_inputs(v);
    load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          digits    dp_i     en       blink    lzb   lit      seg {d3,d2,d1,d0}                dp out
    vecs[0] = {16'h12AF, 4'h0,    4'hF,    4'h0,    1'b0, 4'hF,    {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF};
    vecs[1] = {16'h0070, 4'b1000, 4'hF,    4'h0,    1'b1, 4'b0011, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0111};
    vecs[2] = {16'h9653, 4'b0010, 4'b1010, 4'h0,    1'b0, 4'b1010, {7'h10, 7'h7F, 7'h12, 7'h7F}, 4'b1101};
    vecs[3] = {16'hBCDE, 4'hF,    4'hF,    4'h0,    1'b0, 4'hF,    {7'h03, 7'h46, 7'h21, 7'h06}, 4'h0};
    vecs[4] = {16'h0408, 4'h0,    4'hF,    4'h0,    1'b1, 4'b0111, {7'h7F, 7'h19, 7'h40, 7'h00}, 4'hF};
    vecs[5] = {16'h0000, 4'h0,    4'hF,    4'h0,    1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
    vecs[6] = {16'h3698, 4'h0,    4'hF,    4'h0,    1'b0, 4'hF,    {7'h30, 7'h02, 7'h10, 7'h00}, 4'hF};
    dark_v      = {16'h0000, 4'h0, 4'h0, 4'h0,    1'b0, 4'h0,    {4{7'h7F}}, 4'hF};
    blink_on_v  = {16'h1111, 4'h0, 4'hF, 4'b0001, 1'b0, 4'hF,    {4{7'h79}}, 4'hF};
    blink_off_v = {16'h1111, 4'h0, 4'hF, 4'b0001, 1'b0, 4'b1110, {4{7'h79}}, 4'hF};

    // Reset state, then a dark display for three frames with 32-cycle frame pulses.
    @(negedge clk);
    @(negedge clk);
    chk("reset values", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    wait_frame("idle");
    for (int f = 0; f < 3; f++) check_frame(dark_v, $sformatf("idle f%0d", f));

    // Table vectors: decode, dp, enable mask, leading-zero blanking.
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i]);
      wait_frame($sformatf("vec%0d", i));
      check_frame(vecs[i], $sformatf("vec%0d", i));
    end

    // Blink: from reset, frame 1 lit, frames 2-3 dark, frames 4-5 lit.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(blink_on_v);
    wait_frame("blink");
    check_frame(blink_on_v,  "blink f1");
    check_frame(blink_off_v, "blink f2");
    check_frame(blink_off_v, "blink f3");
    check_frame(blink_on_v,  "blink f4");
    check_frame(blink_on_v,  "blink f5");

    // Pending load: pulse at 5, inputs change at 20, second pulse at 25; capture at frame end.
    for (int fc = 1; fc <= 5; fc++) @(negedge clk);
    set_inputs(vecs[0]);
    load_i = 1'b1;
    for (int fc = 6; fc < N*RD; fc++) begin
      @(negedge clk);
      if (fc == 6) load_i = 1'b0;
      chk($sformatf("pending c%0d", fc), {12'd0, frame_o, load_pending_o}, 14'b01);
      if (fc == 20) set_inputs(vecs[1]);
      if (fc == 25) load_i = 1'b1;
      if (fc == 26) load_i = 1'b0;
    end
    @(negedge clk);
    chk("pending falls with frame_o", {12'd0, frame_o, load_pending_o}, 14'b10);
    check_frame(vecs[1], "late inputs");

    // Reset mid-slot while a load is pending: everything returns to reset, load lost.
    for (int fc = 1; fc <= 10; fc++) @(negedge clk);
    apply(vecs[3]);
    chk("pending before reset", {13'd0, load_pending_o}, 14'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid-frame reset", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    wait_frame("post reset");
    check_frame(dark_v, "post reset f0");
    check_frame(dark_v, "post reset f1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
